reset_req_gen: RTL and testbench

Reset request generator: the source end of the system reset path. Turns the front-panel reset button (async, bouncy, active-low) and an optional PS/2 keyboard reset strobe into a clean, fixed-width, active-low reset request `rst_req_n`. Top level ANDs `rst_req_n` with the board reset and feeds the result to the power-on reset stretcher, which then holds the CPU/video in reset. Exactly one reset pulse per button press.

---
 rtl/reset_req_gen.sv | 125 ++++++++++++
 tb/tb_reset_req_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_req_gen.sv
// Reset request generator: debounced front-panel button (and optional keyboard strobe) to a fixed-width active-low reset request.
// Define RESET_REQ_KBD_EN to honour kbd_reset; otherwise only the button can request a reset.
module reset_req_gen #(
    parameter int CNT_W     = 8,
    parameter int DB_CNT    = 16,
    parameter int PULSE_LEN = 8
) (
    input  logic clk25,
    input  logic rst_n,
    input  logic enable,
    input  logic btn_n,
    input  logic kbd_reset,
    output logic rst_req_n,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        ASSERT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             s1;
    logic             s2;
    logic             pressed;
    logic             kbd_go;

`ifdef RESET_REQ_KBD_EN
    assign kbd_go = kbd_reset;
`else
    logic kbd_unused;
    assign kbd_unused = kbd_reset;
    assign kbd_go     = 1'b0;
`endif

    // Button is asynchronous; both stages idle at "released" so reset never looks like a press.
    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    assign pressed = ~s2;

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rst_req_n <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rst_req_n <= (state_nx != ASSERT);
            busy      <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (kbd_go) begin
                    state_nx = ASSERT;
                    cnt_nx   = '0;
                end else if (pressed) begin
                    state_nx = DEBOUNCE;
                    cnt_nx   = '0;
                end
            end
            DEBOUNCE: begin
                if (enable) begin
                    if (!pressed) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == DB_LAST) begin
                        state_nx = ASSERT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            // Pulse width counts raw clk25 cycles so it is independent of the sample strobe.
            ASSERT: begin
                if (cnt == PULSE_LAST) begin
                    state_nx = WAIT_REL;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (enable) begin
                    if (pressed) begin
                        cnt_nx = '0;
                    end else if (cnt == DB_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_req_gen.sv
// Testbench for reset_req_gen: cycle-level behavioural model plus directed scenarios with hand-computed edge numbers.
`timescale 1ns/1ps
module tb_reset_req_gen;

    localparam int DB = 4;
    localparam int PL = 8;
`ifdef RESET_REQ_KBD_EN
    localparam bit KBD_ON = 1'b1;
`else
    localparam bit KBD_ON = 1'b0;
`endif

    logic clk25;
    logic rst_n;
    logic enable;
    logic btn_n;
    logic kbd_reset;
    logic rst_req_n;
    logic busy;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;
    int last_start = 0;
    int en_div = 0;
    bit check_en = 0;

    int pulses = 0;
    int busy_rises = 0;
    int fall_edge = 0;
    int rise_edge = 0;
    int busy_fall_edge = 0;
    logic prev_req = 1'b1;
    logic prev_busy = 1'b0;

    bit hist1 = 1;
    bit hist2 = 1;
    int pulse_left = 0;
    bit waiting = 0;
    bit debouncing = 0;
    int press_run = 0;
    int rel_run = 0;

    reset_req_gen #(.CNT_W(8), .DB_CNT(DB), .PULSE_LEN(PL)) dut (
        .clk25    (clk25),
        .rst_n    (rst_n),
        .enable   (enable),
        .btn_n    (btn_n),
        .kbd_reset(kbd_reset),
        .rst_req_n(rst_req_n),
        .busy     (busy)
    );

    initial begin
        clk25 = 1'b0;
        forever #20 clk25 = ~clk25;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic b, input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk25);
            if (i == 0) last_start = edge_no + 1;
            rst_n     = r;
            enable    = (en_div > 0) ? ((i % en_div) == 0) : e;
            btn_n     = b;
            kbd_reset = k;
            @(posedge clk25);
        end
    endtask

    // Model: a pulse is a countdown; a press needs DB enabled pressed samples, a release DB enabled released samples in a row.
    always @(posedge clk25) begin
        bit pressed_m;
        edge_no++;
        pressed_m = !hist2;
        if (!rst_n) begin
            hist1 = 1; hist2 = 1; pulse_left = 0; waiting = 0;
            debouncing = 0; press_run = 0; rel_run = 0;
        end else begin
            hist2 = hist1;
            hist1 = btn_n;
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) begin
                    waiting = 1;
                    rel_run = 0;
                end
            end else if (waiting) begin
                if (enable) begin
                    rel_run = pressed_m ? 0 : rel_run + 1;
                    if (rel_run == DB) waiting = 0;
                end
            end else if (debouncing) begin
                if (enable) begin
                    if (pressed_m) begin
                        press_run++;
                        if (press_run == DB) begin
                            debouncing = 0;
                            pulse_left = PL;
                        end
                    end else begin
                        debouncing = 0;
                    end
                end
            end else if (KBD_ON && kbd_reset) begin
                pulse_left = PL;
            end else if (pressed_m) begin
                debouncing = 1;
                press_run = 0;
            end
        end
        #1;
        if (check_en) begin
            checkOutput("rst_req_n", rst_req_n, (pulse_left == 0));
            checkOutput("busy", busy, (pulse_left > 0) || waiting || debouncing);
            if (prev_req && !rst_req_n) begin
                pulses++;
                fall_edge = edge_no;
            end
            if (!prev_req && rst_req_n) rise_edge = edge_no;
            if (!prev_busy && busy) busy_rises++;
            if (prev_busy && !busy) busy_fall_edge = edge_no;
        end
        prev_req = rst_req_n;
        prev_busy = busy;
    end

    initial begin
        int p0;
        int b0;
        int s;
        rst_n = 1'b0; enable = 1'b1; btn_n = 1'b1; kbd_reset = 1'b0;

        applyStimulus(0, 1, 1, 0, 3);
        check_en = 1;
        #2;
        checkOutput("reset_rst_req_n", rst_req_n, 1);
        checkOutput("reset_busy", busy, 0);
        applyStimulus(1, 1, 1, 0, 5);

        // Long press: pulse at start+6 .. start+13, busy drops 5 edges after release is first sampled.
        p0 = pulses;
        applyStimulus(1, 1, 0, 0, 100);
        s = last_start;
        #2;
        checkOutput("press_fall_edge", fall_edge - s, 2 + DB);
        checkOutput("press_width", rise_edge - fall_edge, PL);
        applyStimulus(1, 1, 1, 0, 30);
        #2;
        checkOutput("press_busy_fall", busy_fall_edge - last_start, 1 + DB);
        checkOutput("press_pulses", pulses - p0, 1);

        // Short glitch: debounce starts and aborts.
        p0 = pulses; b0 = busy_rises;
        applyStimulus(1, 1, 0, 0, 3);
        applyStimulus(1, 1, 1, 0, 20);
        #2;
        checkOutput("glitch_pulses", pulses - p0, 0);
        checkOutput("glitch_busy_rises", busy_rises - b0, 1);
        checkOutput("glitch_busy_end", busy, 0);

        // Keyboard strobe in IDLE.
        p0 = pulses; b0 = busy_rises;
        applyStimulus(1, 1, 1, 1, 1);
        s = last_start;
        applyStimulus(1, 1, 1, 0, 30);
        #2;
`ifdef RESET_REQ_KBD_EN
        checkOutput("kbd_fall_edge", fall_edge - s, 0);
        checkOutput("kbd_width", rise_edge - fall_edge, PL);
        checkOutput("kbd_pulses", pulses - p0, 1);
`else
        checkOutput("kbd_pulses", pulses - p0, 0);
        checkOutput("kbd_busy_rises", busy_rises - b0, 0);
`endif

        // Sparse enable: debounce slows, pulse width does not.
        p0 = pulses;
        en_div = 4;
        applyStimulus(1, 1, 0, 0, 60);
        applyStimulus(1, 1, 1, 0, 40);
        en_div = 0;
        #2;
        checkOutput("sparse_pulses", pulses - p0, 1);
        checkOutput("sparse_width", rise_edge - fall_edge, PL);

        // Reset during the third ASSERT cycle, then a fresh press while still held.
        p0 = pulses;
        applyStimulus(1, 1, 0, 0, 9);
        s = last_start;
        applyStimulus(0, 1, 0, 0, 1);
        #2;
        checkOutput("rst_mid_rise", rise_edge - s, 2 + DB + 3);
        checkOutput("rst_mid_busy", busy, 0);
        applyStimulus(1, 1, 0, 0, 30);
        s = last_start;
        #2;
        checkOutput("rst_refall", fall_edge - s, 2 + DB);
        checkOutput("rst_rewidth", rise_edge - fall_edge, PL);
        applyStimulus(1, 1, 1, 0, 30);
        #2;
        checkOutput("rst_pulses", pulses - p0, 2);

        // Keyboard strobes during ASSERT and WAIT_REL are dropped.
        p0 = pulses;
        applyStimulus(1, 1, 0, 0, 9);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 10);
        applyStimulus(1, 1, 0, 1, 1);
        applyStimulus(1, 1, 0, 0, 10);
        applyStimulus(1, 1, 1, 0, 30);
        #2;
        checkOutput("kbd_busy_pulses", pulses - p0, 1);
        checkOutput("kbd_busy_width", rise_edge - fall_edge, PL);
        checkOutput("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
